// File: rtl/exc_commit_ctrl_pkg.sv
// Shared exception codes, exception-bit positions and FSM state type for the
// commit-stage exception controller.
package exc_commit_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_TR   = 5'h0D;
    localparam logic [4:0] EXC_ERET = 5'h1F;

    localparam logic [4:0] CP0_REG_EPC = 5'd14;

    // Bit positions inside slotN_exc_i = {eret, ades, adel_mem, bp, sys, ov_tr, ri}
    localparam int BIT_RI       = 0;
    localparam int BIT_OV_TR    = 1;
    localparam int BIT_SYS      = 2;
    localparam int BIT_BP       = 3;
    localparam int BIT_ADEL_MEM = 4;
    localparam int BIT_ADES     = 5;
    localparam int BIT_ERET     = 6;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_GUARD
    } state_e;

    // Interrupt is taken only when some enabled line is pending, EXL is clear and IE is set.
    function automatic logic int_pending(input logic [7:0] ip, input logic [7:0] im,
                                         input logic exl, input logic ie);
        return (|(ip & im)) && !exl && ie;
    endfunction

endpackage

// File: rtl/exc_commit_ctrl_slot_prio.sv
// Per-slot exception priority encoder: picks the highest-priority cause for one
// committing instruction.
module exc_slot_prio
    import exc_commit_ctrl_pkg::*;
(
    input  logic       valid_i,
    input  logic [6:0] exc_i,
    input  logic       tr_i,
    input  logic [1:0] pc_lo_i,
    input  logic       int_i,
    output logic       hit_o,
    output logic [4:0] code_o,
    output logic       fetch_adel_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the chain infers a latch.
        hit_o        = 1'b0;
        code_o       = EXC_INT;
        fetch_adel_o = 1'b0;
        if (valid_i) begin
            hit_o = 1'b1;
            if (int_i) begin
                code_o = EXC_INT;
            end else if (pc_lo_i != 2'b00) begin
                code_o       = EXC_ADEL;
                fetch_adel_o = 1'b1;
            end else if (exc_i[BIT_RI]) begin
                code_o = EXC_RI;
            end else if (exc_i[BIT_OV_TR]) begin
                code_o = tr_i ? EXC_TR : EXC_OV;
            end else if (exc_i[BIT_SYS]) begin
                code_o = EXC_SYS;
            end else if (exc_i[BIT_BP]) begin
                code_o = EXC_BP;
            end else if (exc_i[BIT_ADEL_MEM]) begin
                code_o = EXC_ADEL;
            end else if (exc_i[BIT_ADES]) begin
                code_o = EXC_ADES;
            end else if (exc_i[BIT_ERET]) begin
                code_o = EXC_ERET;
            end else begin
                hit_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception controller: selects one precise exception or ERET per
// cycle, registers the event toward CP0 and sequences the pipeline flush.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slot1_valid_i,
    input  logic              slot2_valid_i,
    input  logic [6:0]        slot1_exc_i,
    input  logic [6:0]        slot2_exc_i,
    input  logic              slot1_tr_i,
    input  logic              slot2_tr_i,
    input  logic [ADDR_W-1:0] slot1_pc_i,
    input  logic [ADDR_W-1:0] slot2_pc_i,
    input  logic              slot1_ds_i,
    input  logic              slot2_ds_i,
    input  logic [31:0]       slot1_mem_addr_i,
    input  logic [31:0]       slot2_mem_addr_i,
    input  logic [31:0]       status_i,
    input  logic [31:0]       cause_i,
    input  logic [31:0]       epc_i,
    input  logic [31:0]       ebase_i,
    input  logic              cp0_we_i,
    input  logic [4:0]        cp0_waddr_i,
    input  logic [31:0]       cp0_wdata_i,
    output logic              exception_flag_o,
    output logic [4:0]        exception_type_o,
    output logic              exception_first_inst_o,
    output logic [ADDR_W-1:0] inst1_addr_o,
    output logic [ADDR_W-1:0] inst2_addr_o,
    output logic              is_in_delayslot1_o,
    output logic              is_in_delayslot2_o,
    output logic [31:0]       mem_addr_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] new_pc_o,
    output logic              slot2_kill_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_q, flag_d;
    logic [4:0]         type_q, type_d;
    logic               first_q, first_d;
    logic [ADDR_W-1:0]  inst1_q, inst1_d, inst2_q, inst2_d;
    logic               ds1_q, ds1_d, ds2_q, ds2_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  new_pc_q, new_pc_d;

    logic       int_pend, idle;
    logic       s1_hit, s2_hit, s1_fetch, s2_fetch;
    logic [4:0] s1_code, s2_code, sel_code;
    logic       unused_bits;

    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    assign int_pend = int_pending(cause_i[15:8], status_i[15:8], status_i[1], status_i[0]);
    assign idle     = (state_q == S_IDLE);

    // The interrupt rides on the oldest valid instruction only.
    exc_slot_prio u_prio1 (
        .valid_i      (slot1_valid_i),
        .exc_i        (slot1_exc_i),
        .tr_i         (slot1_tr_i),
        .pc_lo_i      (slot1_pc_i[1:0]),
        .int_i        (int_pend),
        .hit_o        (s1_hit),
        .code_o       (s1_code),
        .fetch_adel_o (s1_fetch)
    );

    exc_slot_prio u_prio2 (
        .valid_i      (slot2_valid_i),
        .exc_i        (slot2_exc_i),
        .tr_i         (slot2_tr_i),
        .pc_lo_i      (slot2_pc_i[1:0]),
        .int_i        (int_pend && !slot1_valid_i),
        .hit_o        (s2_hit),
        .code_o       (s2_code),
        .fetch_adel_o (s2_fetch)
    );

    assign sel_code     = s1_hit ? s1_code : s2_code;
    assign slot2_kill_o = !rst && idle && s1_hit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flag_d     = 1'b0;
        type_d     = type_q;
        first_d    = first_q;
        inst1_d    = inst1_q;
        inst2_d    = inst2_q;
        ds1_d      = ds1_q;
        ds2_d      = ds2_q;
        mem_addr_d = mem_addr_q;
        new_pc_d   = new_pc_q;
        case (state_q)
            S_IDLE: begin
                if (s1_hit || s2_hit) begin
                    state_d  = S_FLUSH;
                    cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
                    flag_d   = 1'b1;
                    type_d   = sel_code;
                    first_d  = s1_hit;
                    inst1_d  = slot1_pc_i;
                    inst2_d  = slot2_pc_i;
                    ds1_d    = slot1_ds_i;
                    ds2_d    = slot2_ds_i;
                    if (s1_hit) begin
                        mem_addr_d = s1_fetch ? 32'(slot1_pc_i) : slot1_mem_addr_i;
                    end else begin
                        mem_addr_d = s2_fetch ? 32'(slot2_pc_i) : slot2_mem_addr_i;
                    end
                    // A slot-2 ERET must see an EPC written by the MTC0 in slot 1 of the same bundle.
                    if (sel_code == EXC_ERET) begin
                        if (!s1_hit && cp0_we_i && (cp0_waddr_i == CP0_REG_EPC)) begin
                            new_pc_d = ADDR_W'(cp0_wdata_i);
                        end else begin
                            new_pc_d = ADDR_W'(epc_i);
                        end
                    end else begin
                        new_pc_d = ADDR_W'(ebase_i);
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_GUARD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GUARD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            flag_q     <= 1'b0;
            type_q     <= '0;
            first_q    <= 1'b0;
            inst1_q    <= '0;
            inst2_q    <= '0;
            ds1_q      <= 1'b0;
            ds2_q      <= 1'b0;
            mem_addr_q <= '0;
            new_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            type_q     <= type_d;
            first_q    <= first_d;
            inst1_q    <= inst1_d;
            inst2_q    <= inst2_d;
            ds1_q      <= ds1_d;
            ds2_q      <= ds2_d;
            mem_addr_q <= mem_addr_d;
            new_pc_q   <= new_pc_d;
        end
    end

    assign exception_flag_o       = flag_q;
    assign exception_type_o       = type_q;
    assign exception_first_inst_o = first_q;
    assign inst1_addr_o           = inst1_q;
    assign inst2_addr_o           = inst2_q;
    assign is_in_delayslot1_o     = ds1_q;
    assign is_in_delayslot2_o     = ds2_q;
    assign mem_addr_o             = mem_addr_q;
    assign flush_o                = (state_q == S_FLUSH);
    assign new_pc_o               = new_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a rule-level reference model.
module tb_exc_commit_ctrl;

    localparam int FC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        slot1_valid_i, slot2_valid_i;
    logic [6:0]  slot1_exc_i, slot2_exc_i;
    logic        slot1_tr_i, slot2_tr_i;
    logic [31:0] slot1_pc_i, slot2_pc_i;
    logic        slot1_ds_i, slot2_ds_i;
    logic [31:0] slot1_mem_addr_i, slot2_mem_addr_i;
    logic [31:0] status_i, cause_i, epc_i, ebase_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic        exception_flag_o, exception_first_inst_o;
    logic [4:0]  exception_type_o;
    logic [31:0] inst1_addr_o, inst2_addr_o, mem_addr_o, new_pc_o;
    logic        is_in_delayslot1_o, is_in_delayslot2_o, flush_o, slot2_kill_o;

    int checks = 0;
    int errors = 0;

    exc_commit_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .slot1_valid_i(slot1_valid_i), .slot2_valid_i(slot2_valid_i),
        .slot1_exc_i(slot1_exc_i), .slot2_exc_i(slot2_exc_i),
        .slot1_tr_i(slot1_tr_i), .slot2_tr_i(slot2_tr_i),
        .slot1_pc_i(slot1_pc_i), .slot2_pc_i(slot2_pc_i),
        .slot1_ds_i(slot1_ds_i), .slot2_ds_i(slot2_ds_i),
        .slot1_mem_addr_i(slot1_mem_addr_i), .slot2_mem_addr_i(slot2_mem_addr_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .ebase_i(ebase_i),
        .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
        .exception_flag_o(exception_flag_o), .exception_type_o(exception_type_o),
        .exception_first_inst_o(exception_first_inst_o),
        .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
        .is_in_delayslot1_o(is_in_delayslot1_o), .is_in_delayslot2_o(is_in_delayslot2_o),
        .mem_addr_o(mem_addr_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .slot2_kill_o(slot2_kill_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s1v, s2v;
        logic [6:0]  s1e, s2e;
        logic        s1tr, s2tr;
        logic [31:0] s1pc, s2pc;
        logic        s1ds, s2ds;
        logic [31:0] s1ma, s2ma, status, cause, epc, ebase;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        x_flag;
        logic [4:0]  x_type;
        logic        x_first;
        logic [31:0] x_ma, x_pc;
        logic        x_kill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v.s1v = 0; v.s2v = 0; v.s1e = '0; v.s2e = '0; v.s1tr = 0; v.s2tr = 0;
        v.s1pc = 32'hBFC00100; v.s2pc = 32'hBFC00104; v.s1ds = 0; v.s2ds = 0;
        v.s1ma = 32'h11110000; v.s2ma = 32'h22220000;
        v.status = 32'h0; v.cause = 32'h0; v.epc = 32'h0; v.ebase = 32'hBFC00380;
        v.we = 0; v.waddr = '0; v.wdata = '0;
        v.x_flag = 0; v.x_type = '0; v.x_first = 0; v.x_ma = '0; v.x_pc = '0; v.x_kill = 0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        slot1_valid_i = v.s1v;  slot2_valid_i = v.s2v;
        slot1_exc_i = v.s1e;    slot2_exc_i = v.s2e;
        slot1_tr_i = v.s1tr;    slot2_tr_i = v.s2tr;
        slot1_pc_i = v.s1pc;    slot2_pc_i = v.s2pc;
        slot1_ds_i = v.s1ds;    slot2_ds_i = v.s2ds;
        slot1_mem_addr_i = v.s1ma; slot2_mem_addr_i = v.s2ma;
        status_i = v.status; cause_i = v.cause; epc_i = v.epc; ebase_i = v.ebase;
        cp0_we_i = v.we; cp0_waddr_i = v.waddr; cp0_wdata_i = v.wdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(idle_vec());
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: the spec's priority list evaluated first-match over a table.
    task automatic ref_slot(input logic v, input logic [6:0] e, input logic tr, input logic [31:0] pc,
                            input logic intr, output logic hit, output logic [4:0] code, output logic fetch);
        logic       c[9];
        logic [4:0] k[9];
        c = '{intr, pc[1:0] != 2'b00, e[0], e[1], e[2], e[3], e[4], e[5], e[6]};
        k = '{5'h00, 5'h04, 5'h0A, tr ? 5'h0D : 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05, 5'h1F};
        hit = 0; code = '0; fetch = 0;
        if (v) begin
            for (int i = 0; i < 9; i++) begin
                if (c[i]) begin
                    hit = 1; code = k[i]; fetch = (i == 1);
                    break;
                end
            end
        end
    endtask

    task automatic ref_event(output logic hit, output logic first, output logic [4:0] code,
                             output logic [31:0] ma, output logic [31:0] npc);
        logic       ip, h1, h2, f1, f2;
        logic [4:0] c1, c2;
        ip = (|(cause_i[15:8] & status_i[15:8])) && !status_i[1] && status_i[0];
        ref_slot(slot1_valid_i, slot1_exc_i, slot1_tr_i, slot1_pc_i, ip, h1, c1, f1);
        ref_slot(slot2_valid_i, slot2_exc_i, slot2_tr_i, slot2_pc_i, ip && !slot1_valid_i, h2, c2, f2);
        hit   = h1 || h2;
        first = h1;
        code  = h1 ? c1 : c2;
        ma    = h1 ? (f1 ? slot1_pc_i : slot1_mem_addr_i) : (f2 ? slot2_pc_i : slot2_mem_addr_i);
        npc   = ebase_i;
        if (code == 5'h1F)
            npc = (!h1 && cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
    endtask

    task automatic rand_inputs();
        vec_t v;
        v = idle_vec();
        v.s1v = 1'($urandom); v.s2v = 1'($urandom);
        v.s1e = 7'($urandom & $urandom & $urandom);
        v.s2e = 7'($urandom & $urandom & $urandom);
        v.s1tr = 1'($urandom); v.s2tr = 1'($urandom);
        v.s1pc = $urandom; v.s2pc = $urandom;
        if ($urandom_range(0, 7) != 0) v.s1pc[1:0] = 2'b00;
        if ($urandom_range(0, 7) != 0) v.s2pc[1:0] = 2'b00;
        v.s1ds = 1'($urandom); v.s2ds = 1'($urandom);
        v.s1ma = $urandom; v.s2ma = $urandom;
        v.status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
        v.cause = {16'h0, 8'($urandom & $urandom), 8'h0};
        v.epc = $urandom; v.ebase = $urandom;
        v.we = ($urandom_range(0, 2) == 0);
        v.waddr = $urandom_range(0, 1) ? 5'd14 : 5'($urandom);
        v.wdata = $urandom;
        drive(v);
    endtask

    initial begin
        vec_t v;
        logic        r_hit, r_first;
        logic [4:0]  r_code;
        logic [31:0] r_ma, r_pc;
        int          since;
        logic        m_flag, m_first;
        logic [4:0]  m_type;
        logic [31:0] m_ma, m_pc;

        // Directed vectors, each applied from IDLE.
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000100;
        v.x_flag = 1; v.x_type = 5'h08; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1pc = 32'hBFC00200; v.s2v = 1; v.s2e = 7'b0010000; v.s2ds = 1;
        v.s2pc = 32'hBFC00204; v.s2ma = 32'h80000003;
        v.x_flag = 1; v.x_type = 5'h04; v.x_first = 0; v.x_ma = 32'h80000003; v.x_pc = 32'hBFC00380;
        vecs.push_back(v);
        v = idle_vec(); v.s2v = 1; v.status = 32'h0000FF01; v.cause = 32'h00000400;
        v.x_flag = 1; v.x_type = 5'h00; v.x_first = 0; v.x_ma = 32'h22220000; v.x_pc = 32'hBFC00380;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s2v = 1; v.s2e = 7'b1000000; v.we = 1; v.waddr = 5'd14; v.wdata = 32'h80001000;
        v.x_flag = 1; v.x_type = 5'h1F; v.x_first = 0; v.x_ma = 32'h22220000; v.x_pc = 32'h80001000;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b1000000; v.epc = 32'h80000200; v.we = 1; v.waddr = 5'd14; v.wdata = 32'h12345678;
        v.x_flag = 1; v.x_type = 5'h1F; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'h80000200; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s2v = 1; v.s2e = 7'b1000000; v.epc = 32'h80000300; v.we = 1; v.waddr = 5'd12; v.wdata = 32'h12345678;
        v.x_flag = 1; v.x_type = 5'h1F; v.x_first = 0; v.x_ma = 32'h22220000; v.x_pc = 32'h80000300;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1pc = 32'hBFC00102; v.s1e = 7'b0000001;
        v.x_flag = 1; v.x_type = 5'h04; v.x_first = 1; v.x_ma = 32'hBFC00102; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000011;
        v.x_flag = 1; v.x_type = 5'h0A; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000110; v.s1tr = 0;
        v.x_flag = 1; v.x_type = 5'h0C; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000010; v.s1tr = 1;
        v.x_flag = 1; v.x_type = 5'h0D; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0011000;
        v.x_flag = 1; v.x_type = 5'h09; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b1100000;
        v.x_flag = 1; v.x_type = 5'h05; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000100; v.s2v = 1; v.s2e = 7'b0000001;
        v.x_flag = 1; v.x_type = 5'h08; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000100; v.status = 32'h0000FF01; v.cause = 32'h00000400;
        v.x_flag = 1; v.x_type = 5'h00; v.x_first = 1; v.x_ma = 32'h11110000; v.x_pc = 32'hBFC00380; v.x_kill = 1;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.status = 32'h0000FF03; v.cause = 32'h00000400;
        vecs.push_back(v);
        v = idle_vec(); v.s1e = 7'b0000100; v.s1pc = 32'hBFC00101; v.s2v = 1;
        vecs.push_back(v);
        v = idle_vec(); v.status = 32'h0000FF01; v.cause = 32'h00000400;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.status = 32'h00000401; v.cause = 32'h00000800;
        vecs.push_back(v);
        v = idle_vec(); v.s1v = 1; v.status = 32'h0000FF00; v.cause = 32'h00000400;
        vecs.push_back(v);

        do_reset();
        rst = 1'b1;
        #1;
        check("reset flag", exception_flag_o, 0);
        check("reset type", exception_type_o, 0);
        check("reset first", exception_first_inst_o, 0);
        check("reset inst1", inst1_addr_o, 0);
        check("reset inst2", inst2_addr_o, 0);
        check("reset ds1", is_in_delayslot1_o, 0);
        check("reset ds2", is_in_delayslot2_o, 0);
        check("reset mem_addr", mem_addr_o, 0);
        check("reset flush", flush_o, 0);
        check("reset new_pc", new_pc_o, 0);
        check("reset kill", slot2_kill_o, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d kill", i), slot2_kill_o, vecs[i].x_kill);
            @(negedge clk);
            drive(idle_vec());
            check($sformatf("vec%0d flag", i), exception_flag_o, vecs[i].x_flag);
            check($sformatf("vec%0d flush", i), flush_o, vecs[i].x_flag);
            if (vecs[i].x_flag) begin
                check($sformatf("vec%0d type", i), exception_type_o, vecs[i].x_type);
                check($sformatf("vec%0d first", i), exception_first_inst_o, vecs[i].x_first);
                check($sformatf("vec%0d mem_addr", i), mem_addr_o, vecs[i].x_ma);
                check($sformatf("vec%0d new_pc", i), new_pc_o, vecs[i].x_pc);
                check($sformatf("vec%0d inst1", i), inst1_addr_o, vecs[i].s1pc);
                check($sformatf("vec%0d inst2", i), inst2_addr_o, vecs[i].s2pc);
                check($sformatf("vec%0d ds1", i), is_in_delayslot1_o, vecs[i].s1ds);
                check($sformatf("vec%0d ds2", i), is_in_delayslot2_o, vecs[i].s2ds);
                repeat (FC) @(negedge clk);
            end
        end

        // Flush length, event ignored during FLUSH/GUARD, accepted the cycle after GUARD.
        @(negedge clk);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000100; drive(v);
        @(negedge clk);
        drive(idle_vec());
        check("seqA flag T+1", exception_flag_o, 1);
        check("seqA flush T+1", flush_o, 1);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000001;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            drive(v);
            #1;
            check($sformatf("seqA flag T+%0d", k), exception_flag_o, 0);
            check($sformatf("seqA flush T+%0d", k), flush_o, k <= FC);
            check($sformatf("seqA kill T+%0d", k), slot2_kill_o, 0);
        end
        @(negedge clk);
        #1;
        check("seqA flag T+5", exception_flag_o, 0);
        check("seqA flush T+5", flush_o, 0);
        check("seqA kill T+5", slot2_kill_o, 1);
        @(negedge clk);
        drive(idle_vec());
        check("seqA flag T+6", exception_flag_o, 1);
        check("seqA type T+6", exception_type_o, 5'h0A);
        repeat (FC) @(negedge clk);

        // Interrupt kept asserted through FLUSH/GUARD gives no second flag.
        @(negedge clk);
        v = idle_vec(); v.s2v = 1; v.status = 32'h0000FF01; v.cause = 32'h00000400; drive(v);
        @(negedge clk);
        check("seqB flag T+1", exception_flag_o, 1);
        check("seqB type T+1", exception_type_o, 5'h00);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("seqB flag T+%0d", k), exception_flag_o, 0);
        end
        @(negedge clk);
        drive(idle_vec());
        check("seqB flag T+5", exception_flag_o, 0);
        @(negedge clk);
        check("seqB flag T+6", exception_flag_o, 0);

        // Reset in the middle of FLUSH.
        @(negedge clk);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000100; v.s1ds = 1; drive(v);
        @(negedge clk);
        drive(idle_vec());
        check("seqC flag T+1", exception_flag_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("seqC flag after rst", exception_flag_o, 0);
        check("seqC flush after rst", flush_o, 0);
        check("seqC type after rst", exception_type_o, 0);
        check("seqC new_pc after rst", new_pc_o, 0);
        check("seqC inst1 after rst", inst1_addr_o, 0);
        check("seqC ds1 after rst", is_in_delayslot1_o, 0);
        v = idle_vec(); v.s1v = 1; v.s1e = 7'b0000001; drive(v);
        #1;
        check("seqC kill RI", slot2_kill_o, 1);
        @(negedge clk);
        drive(idle_vec());
        check("seqC flag RI", exception_flag_o, 1);
        check("seqC type RI", exception_type_o, 5'h0A);
        check("seqC flush RI", flush_o, 1);
        repeat (FC) @(negedge clk);

        // Randomized traffic against the reference model.
        do_reset();
        since = 0; m_flag = 0; m_first = 0; m_type = '0; m_ma = '0; m_pc = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            check("rnd flag", exception_flag_o, m_flag);
            check("rnd flush", flush_o, (since >= 1 && since <= FC));
            check("rnd new_pc", new_pc_o, m_pc);
            if (m_flag) begin
                check("rnd type", exception_type_o, m_type);
                check("rnd first", exception_first_inst_o, m_first);
                check("rnd mem_addr", mem_addr_o, m_ma);
            end
            rand_inputs();
            #1;
            ref_event(r_hit, r_first, r_code, r_ma, r_pc);
            check("rnd kill", slot2_kill_o, since == 0 && r_hit && r_first);
            if (since == 0 && r_hit) begin
                m_flag = 1; m_first = r_first; m_type = r_code; m_ma = r_ma; m_pc = r_pc;
                since = 1;
            end else begin
                m_flag = 0;
                if (since == FC + 1) since = 0;
                else if (since != 0) since++;
            end
        end
        @(negedge clk);
        check("rnd final flag", exception_flag_o, m_flag);
        drive(idle_vec());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
